// File: rtl/sr_chk_pkg.sv
// Shared types, input-code constants and the saturating-increment helper
// used by the SR latch checker and its event counters.
package sr_chk_pkg;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        SETTLE  = 2'd1,
        STABLE  = 2'd2,
        FORBID  = 2'd3
    } chk_state_t;

    // Input code is {s, r}
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] FORB = 2'b11;

    // Settle counter is wide enough for SETTLE_CYCLES up to 15
    localparam int SETTLE_W = 4;

    // Increment that sticks at the all-ones value of a 'width'-bit counter
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [63:0] max_val;
        max_val = (64'd1 << width) - 64'd1;
        if ({32'd0, value} >= max_val) begin
            return value;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/sr_latch_checker_sat_counter.sv
// Saturating event counter: synchronous reset, enable-gated clear and
// increment, clear wins over a same-cycle increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    import sr_chk_pkg::*;

    // Count register: reset, then clear, then saturating increment
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (clr) begin
                count <= '0;
            end else if (inc) begin
                count <= WIDTH'(sat_inc(32'(count), WIDTH));
            end
        end
    end

endmodule

// File: rtl/sr_latch_checker.sv
// Clocked observer for NOR/NAND SR latches with active-high S/R.
// Tracks the expected latch output from the sampled {s,r} code, checks
// qa/qb once the code has settled, and counts code entries and errors.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   UNKNOWN | latch value indeterminate (after reset or 11->00 release)
//   SETTLE  | code recently changed, waiting settle counter to reach 0
//   STABLE  | expected value known and settled, qa/qb checked each cycle
//   FORBID  | code 11 held, both outputs checked against NAND_MODE level
module sr_latch_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8,
    parameter bit NAND_MODE     = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_cnt,
    input  logic             s,
    input  logic             r,
    input  logic             qa,
    input  logic             qb,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             forbidden,
    output logic             err_mismatch,
    output logic             err_comp,
    output logic             err_sticky,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] reset_cnt,
    output logic [CNT_W-1:0] forb_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    import sr_chk_pkg::*;

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    chk_state_t          state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [1:0]          prev_q;
    logic                exp_r, exp_d;
    logic [1:0]          code;
    logic                change;
    logic                mis_d, comp_d;

    assign code   = {s, r};
    assign change = (code != prev_q);

    // Next-state, settle timer and error detection for the current sample
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        exp_d    = exp_r;
        mis_d    = 1'b0;
        comp_d   = 1'b0;
        unique case (state_q)
            UNKNOWN: begin
                settle_d = SETTLE_LOAD;
                case (code)
                    SET: begin
                        state_d = SETTLE;
                        exp_d   = 1'b1;
                    end
                    RST: begin
                        state_d = SETTLE;
                        exp_d   = 1'b0;
                    end
                    FORB:    state_d = FORBID;
                    default: settle_d = settle_q;
                endcase
            end
            SETTLE: begin
                if (change) begin
                    // Any change restarts settling; 00 keeps the last driven value
                    settle_d = SETTLE_LOAD;
                    case (code)
                        SET:     exp_d = 1'b1;
                        RST:     exp_d = 1'b0;
                        FORB:    state_d = FORBID;
                        default: ;
                    endcase
                end else if (settle_q == '0) begin
                    state_d = STABLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            STABLE: begin
                if (change && (code != HOLD)) begin
                    // The sample that moves the code is not checked: the
                    // latch is legitimately switching during that cycle.
                    settle_d = SETTLE_LOAD;
                    if (code == FORB) begin
                        state_d = FORBID;
                    end else begin
                        state_d = SETTLE;
                        exp_d   = (code == SET);
                    end
                end else begin
                    mis_d  = (qa != exp_r);
                    comp_d = (qa == qb);
                end
            end
            FORBID: begin
                if (change) begin
                    settle_d = SETTLE_LOAD;
                    case (code)
                        SET: begin
                            state_d = SETTLE;
                            exp_d   = 1'b1;
                        end
                        RST: begin
                            state_d = SETTLE;
                            exp_d   = 1'b0;
                        end
                        default: state_d = UNKNOWN;
                    endcase
                end else if (settle_q == '0) begin
                    mis_d = (qa != NAND_MODE) || (qb != NAND_MODE);
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            default: state_d = UNKNOWN;
        endcase
    end

    // State, model and error-pulse registers; en=0 freezes all but the pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= UNKNOWN;
            settle_q     <= '0;
            prev_q       <= HOLD;
            exp_r        <= 1'b0;
            err_mismatch <= 1'b0;
            err_comp     <= 1'b0;
            err_sticky   <= 1'b0;
        end else if (en) begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            prev_q       <= code;
            exp_r        <= exp_d;
            err_mismatch <= mis_d;
            err_comp     <= comp_d;
            err_sticky   <= clr_cnt ? 1'b0 : (err_sticky | mis_d | comp_d);
        end else begin
            err_mismatch <= 1'b0;
            err_comp     <= 1'b0;
        end
    end

    assign exp_q     = exp_r;
    assign exp_valid = (state_q == STABLE);
    assign forbidden = (state_q == FORBID);

    sat_counter #(.WIDTH(CNT_W)) u_set_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .inc   (change && (code == SET)),
        .clr   (clr_cnt),
        .count (set_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_reset_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .inc   (change && (code == RST)),
        .clr   (clr_cnt),
        .count (reset_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_forb_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .inc   (change && (code == FORB)),
        .clr   (clr_cnt),
        .count (forb_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .inc   (mis_d | comp_d),
        .clr   (clr_cnt),
        .count (err_cnt)
    );

endmodule
